// File: rtl/shift_offset_scheduler.sv
// shift_offset_scheduler: accepts upstream beats, tracks the running byte
// offset within the 64-byte output word, and feeds the first stage of a
// downstream shifter chain. After a last beat, it drains the chain for
// PIPE_DEPTH enabled cycles before it returns to IDLE.
// Optional feature: define SHIFT_SCHED_STATS_EN to enable the beat/wrap
// statistics counters. Without it, stat_beats and stat_wraps read 0.
module shift_offset_scheduler #(
    parameter int unsigned PIPE_DEPTH = 7
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [511:0] in_data,
    input  logic [63:0]  in_keep,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    input  logic         out_ready,
    output logic [511:0] sh_data,
    output logic [63:0]  sh_keep,
    output logic [6:0]   sh_offset,
    output logic         sh_valid,
    output logic         sh_last,
    output logic         sh_last_transfer_flag,
    output logic         sh_enable,
    output logic [6:0]   fill_level,
    output logic [31:0]  stat_beats,
    output logic [31:0]  stat_wraps
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    state_e       state_q, state_d;
    logic [6:0]   fill_q, fill_d;
    logic [3:0]   drain_q, drain_d;
    logic [511:0] sh_data_q, sh_data_d;
    logic [63:0]  sh_keep_q, sh_keep_d;
    logic [6:0]   sh_offset_q, sh_offset_d;
    logic         sh_valid_q, sh_valid_d;
    logic         sh_last_q, sh_last_d;
    logic         sh_flag_q, sh_flag_d;

    logic         accept;
    logic [6:0]   count;
    logic [7:0]   sum;

    assign sh_enable = out_ready;
    assign in_ready  = out_ready && (state_q != FLUSH);
    assign accept    = in_valid && in_ready;

    // Count the bytes in the incoming beat. Keep contiguity is not assumed.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            count = count + {6'd0, in_keep[i]};
        end
    end

    assign sum = {1'b0, fill_q} + {1'b0, count};

    // Next-state logic for the FSM, drain counter, fill level and shifter-stage registers.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        drain_d     = drain_q;
        sh_data_d   = sh_data_q;
        sh_keep_d   = sh_keep_q;
        sh_offset_d = sh_offset_q;
        sh_valid_d  = sh_valid_q;
        sh_last_d   = sh_last_q;
        sh_flag_d   = sh_flag_q;
        if (out_ready) begin
            if (accept) begin
                sh_data_d   = in_data;
                sh_keep_d   = in_keep;
                sh_offset_d = fill_q;
                sh_valid_d  = 1'b1;
                sh_last_d   = in_last;
                sh_flag_d   = (sum >= 8'd64);
                fill_d      = {1'b0, sum[5:0]};
                if (in_last) begin
                    state_d = FLUSH;
                    drain_d = 4'(PIPE_DEPTH);
                end else if (state_q == IDLE) begin
                    state_d = RUN;
                end
            end else begin
                sh_valid_d = 1'b0;
                sh_last_d  = 1'b0;
                sh_flag_d  = 1'b0;
                // The final decrement and the return to IDLE happen on the same
                // edge. This keeps in_ready low for exactly PIPE_DEPTH enabled cycles.
                if (state_q == FLUSH) begin
                    if (drain_q <= 4'd1) begin
                        drain_d = '0;
                        state_d = IDLE;
                        fill_d  = '0;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            fill_q      <= '0;
            drain_q     <= '0;
            sh_data_q   <= '0;
            sh_keep_q   <= '0;
            sh_offset_q <= '0;
            sh_valid_q  <= 1'b0;
            sh_last_q   <= 1'b0;
            sh_flag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            drain_q     <= drain_d;
            sh_data_q   <= sh_data_d;
            sh_keep_q   <= sh_keep_d;
            sh_offset_q <= sh_offset_d;
            sh_valid_q  <= sh_valid_d;
            sh_last_q   <= sh_last_d;
            sh_flag_q   <= sh_flag_d;
        end
    end

    assign sh_data               = sh_data_q;
    assign sh_keep               = sh_keep_q;
    assign sh_offset             = sh_offset_q;
    assign sh_valid              = sh_valid_q;
    assign sh_last               = sh_last_q;
    assign sh_last_transfer_flag = sh_flag_q;
    assign fill_level            = fill_q;

`ifdef SHIFT_SCHED_STATS_EN
    logic [31:0] beats_q, wraps_q;

    // Count accepted beats and accepted beats that complete an output word.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beats_q <= '0;
            wraps_q <= '0;
        end else if (accept) begin
            beats_q <= beats_q + 32'd1;
            if (sh_flag_d) begin
                wraps_q <= wraps_q + 32'd1;
            end
        end
    end

    assign stat_beats = beats_q;
    assign stat_wraps = wraps_q;
`else
    assign stat_beats = '0;
    assign stat_wraps = '0;
`endif

endmodule

// File: tb/tb_shift_offset_scheduler.sv
// Testbench for shift_offset_scheduler. A behavioural model tracks the
// byte fill and the drain length. Directed sequences pin the model with
// literal values, and a randomized stream follows.
module tb_shift_offset_scheduler;

    localparam int unsigned PD = 7;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [511:0] in_data = '0;
    logic [63:0]  in_keep = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         out_ready = 1'b0;
    logic [511:0] sh_data;
    logic [63:0]  sh_keep;
    logic [6:0]   sh_offset;
    logic         sh_valid;
    logic         sh_last;
    logic         sh_last_transfer_flag;
    logic         sh_enable;
    logic [6:0]   fill_level;
    logic [31:0]  stat_beats;
    logic [31:0]  stat_wraps;

    shift_offset_scheduler #(.PIPE_DEPTH(PD)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_data(in_data), .in_keep(in_keep), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_ready(out_ready),
        .sh_data(sh_data), .sh_keep(sh_keep), .sh_offset(sh_offset),
        .sh_valid(sh_valid), .sh_last(sh_last),
        .sh_last_transfer_flag(sh_last_transfer_flag),
        .sh_enable(sh_enable), .fill_level(fill_level),
        .stat_beats(stat_beats), .stat_wraps(stat_wraps)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int           m_fill = 0;
    int           m_flush_left = 0;
    logic [511:0] m_data = '0;
    logic [63:0]  m_keep = '0;
    int           m_off = 0;
    bit           m_valid = 0, m_last = 0, m_flag = 0;
    logic [31:0]  m_beats = '0, m_wraps = '0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] kn(input int n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, then advance the model.
    task automatic step(input bit v, input logic [63:0] k, input bit l, input bit r, input bit rst);
        logic [511:0] d;
        int cnt;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        aresetn = rst; in_valid = v; in_keep = k; in_last = l; out_ready = r; in_data = d;
        #1;
        if (chk_en) begin
            chk("sh_enable", sh_enable, r);
            chk("in_ready", in_ready, r && (m_flush_left == 0));
        end
        @(posedge aclk);
        if (!rst) begin
            m_fill = 0; m_flush_left = 0; m_data = '0; m_keep = '0; m_off = 0;
            m_valid = 0; m_last = 0; m_flag = 0; m_beats = '0; m_wraps = '0;
        end else if (r) begin
            if (v && m_flush_left == 0) begin
                cnt = $countones(k);
                m_data = d; m_keep = k; m_off = m_fill;
                m_flag = (m_fill + cnt) >= 64;
                m_fill = (m_fill + cnt) % 64;
                m_valid = 1; m_last = l;
                m_beats += 1;
                if (m_flag) m_wraps += 1;
                if (l) m_flush_left = PD;
            end else begin
                m_valid = 0; m_last = 0; m_flag = 0;
                if (m_flush_left > 0) begin
                    m_flush_left--;
                    if (m_flush_left == 0) m_fill = 0;
                end
            end
        end
        @(negedge aclk);
    endtask

    // Registered outputs against the model, once per cycle.
    always @(negedge aclk) begin
        if (chk_en) begin
            chk("m_sh_valid", sh_valid, m_valid);
            chk("m_sh_last", sh_last, m_last);
            chk("m_sh_flag", sh_last_transfer_flag, m_flag);
            chk("m_sh_offset", sh_offset, m_off);
            chk("m_sh_data", sh_data, m_data);
            chk("m_sh_keep", sh_keep, m_keep);
            chk("m_fill", fill_level, m_fill);
`ifdef SHIFT_SCHED_STATS_EN
            chk("m_beats", stat_beats, m_beats);
            chk("m_wraps", stat_wraps, m_wraps);
`else
            chk("m_beats", stat_beats, 0);
            chk("m_wraps", stat_wraps, 0);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] k;
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        chk_en = 1'b1;
        chk("rst_valid", sh_valid, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_offset", sh_offset, 0);
        chk("rst_beats", stat_beats, 0);

        // Four 20-byte beats with a three-cycle stall after the second beat.
        step(1, kn(20), 0, 1, 1);
        chk("s27_off0", sh_offset, 0);  chk("s27_flag0", sh_last_transfer_flag, 0);
        step(1, kn(20), 0, 1, 1);
        chk("s27_off1", sh_offset, 20); chk("s27_flag1", sh_last_transfer_flag, 0);
        for (int i = 0; i < 3; i++) step(1, kn(20), 0, 0, 1);
        chk("stall_off", sh_offset, 20); chk("stall_fill", fill_level, 40);
        chk("stall_valid", sh_valid, 1);
        step(1, kn(20), 0, 1, 1);
        chk("s27_off2", sh_offset, 40); chk("s27_flag2", sh_last_transfer_flag, 0);
        step(1, kn(20), 0, 1, 1);
        chk("s27_off3", sh_offset, 60); chk("s27_flag3", sh_last_transfer_flag, 1);
        chk("s27_fill", fill_level, 16);
`ifdef SHIFT_SCHED_STATS_EN
        chk("s32_beats", stat_beats, 4); chk("s32_wraps", stat_wraps, 1);
`else
        chk("s32_beats", stat_beats, 0); chk("s32_wraps", stat_wraps, 0);
`endif
        step(0, '0, 0, 1, 1);
        chk("idle_valid", sh_valid, 0);

        // Full 64-byte beat at fill 0, then an empty beat.
        step(0, '0, 0, 1, 0);
        step(1, kn(64), 0, 1, 1);
        chk("s28_off", sh_offset, 0); chk("s28_flag", sh_last_transfer_flag, 1);
        chk("s28_fill", fill_level, 0);
        step(1, kn(0), 0, 1, 1);
        chk("s28_off0", sh_offset, 0); chk("s28_flag0", sh_last_transfer_flag, 0);
        chk("s28_valid0", sh_valid, 1);

        // Last beat of 10 bytes at fill 30, followed by the drain.
        step(0, '0, 0, 1, 0);
        step(1, kn(30), 0, 1, 1);
        step(1, kn(10), 1, 1, 1);
        chk("s30_last", sh_last, 1); chk("s30_off", sh_offset, 30);
        chk("s30_fill", fill_level, 40);
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step(1, kn(5), 0, 1, 1);
            n++;
        end
        chk("s30_drain_len", n, PD);
        chk("s30_fill_end", fill_level, 0);

        // Reset asserted in the middle of a flush.
        step(1, kn(8), 1, 1, 1);
        step(0, '0, 0, 1, 1);
        step(0, '0, 0, 1, 1);
        step(0, '0, 0, 1, 0);
        chk("s31_valid", sh_valid, 0); chk("s31_last", sh_last, 0);
        chk("s31_off", sh_offset, 0); chk("s31_fill", fill_level, 0);
        chk("s31_ready", in_ready, 1);
        step(0, '0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) k = {$urandom, $urandom};
            else k = kn($urandom_range(0, 64));
            step($urandom_range(0, 3) != 0, k, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
